// File: rtl/alu_operand_sequencer.sv
// Operand/control sequencer for the combinational 8-bit ALU: fetches operands from a small
// register file, holds them on the ALU for one cycle, then writes the result back.
module alu_operand_sequencer #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [5:0]        instr_op,
    input  logic [AW-1:0]     instr_ra,
    input  logic [AW-1:0]     instr_rb,
    input  logic [AW-1:0]     instr_rd,
    input  logic              instr_imm_en,
    input  logic [DATA_W-1:0] instr_imm,
    input  logic              ext_we,
    input  logic [AW-1:0]     ext_waddr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [4:0]        alu_sel,
    output logic              alu_carry_in,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic [AW-1:0]     result_rd,
    output logic              op_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] regs [NREG];
    logic [AW-1:0]     rd_q;
    logic              legal_q;
    logic              accept;
    logic              host_wr;
    logic              wb_wr;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    function automatic logic op_is_legal(input logic [5:0] op);
        logic ok;
        case (op) inside
            6'b000???,
            6'b001000, 6'b001010, 6'b001100, 6'b001110,
            6'b010000, 6'b100000, 6'b110000: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign accept  = (state == IDLE) && instr_valid;
    assign host_wr = (state == IDLE) && ext_we;
    assign wb_wr   = (state == ISSUE) && legal_q;

    // A host write landing on the accept edge is forwarded so the operand sees the new value.
    always_comb begin
        opnd_a = regs[instr_ra];
        opnd_b = regs[instr_rb];
        if (ext_we && (ext_waddr == instr_ra)) opnd_a = ext_wdata;
        if (ext_we && (ext_waddr == instr_rb)) opnd_b = ext_wdata;
        if (instr_imm_en) opnd_b = instr_imm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        instr_ready  = 1'b0;
        result_valid = 1'b0;
        op_err       = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WB;
            WB: begin
                result_valid = legal_q;
                op_err       = !legal_q;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Host writes and ALU write-back are in different states, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (host_wr) begin
            regs[ext_waddr] <= ext_wdata;
        end else if (wb_wr) begin
            regs[rd_q] <= alu_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sel      <= '0;
            alu_carry_in <= 1'b0;
            rd_q         <= '0;
            legal_q      <= 1'b0;
            result_data  <= '0;
            result_rd    <= '0;
        end else begin
            if (accept) begin
                alu_a                   <= opnd_a;
                alu_b                   <= opnd_b;
                {alu_sel, alu_carry_in} <= instr_op;
                rd_q                    <= instr_rd;
                legal_q                 <= op_is_legal(instr_op);
            end
            if (wb_wr) begin
                result_data <= alu_y;
                result_rd   <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: directed vector table, hand-written
// multi-cycle sequences, and randomized instructions against a register-file model.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [5:0] instr_op;
    logic [1:0] instr_ra, instr_rb, instr_rd;
    logic       instr_imm_en;
    logic [7:0] instr_imm;
    logic       ext_we;
    logic [1:0] ext_waddr;
    logic [7:0] ext_wdata;
    logic [4:0] alu_sel;
    logic       alu_carry_in;
    logic [7:0] alu_a, alu_b, alu_y;
    logic       result_valid;
    logic [7:0] result_data;
    logic [1:0] result_rd;
    logic       op_err;

    int vec_count  = 0;
    int miss_count = 0;

    logic [7:0] reg_m [4];
    logic [7:0] res_data_m;
    logic [1:0] res_rd_m;

    logic [5:0] legal_ops [15] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                   6'h08, 6'h0A, 6'h0C, 6'h0E, 6'h10, 6'h20, 6'h30};

    typedef struct {
        logic       ext_we;
        logic [1:0] waddr;
        logic [7:0] wdata;
        logic [5:0] op;
        logic [1:0] ra, rb, rd;
        logic       imm_en;
        logic [7:0] imm;
        logic [7:0] exp_a, exp_b;
        logic       exp_err;
        logic [7:0] exp_rdata;
        logic [1:0] exp_rrd;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU.
    function automatic logic [7:0] alu_model(input logic [4:0] sel, input logic cin,
                                             input logic [7:0] a, input logic [7:0] b);
        logic [7:0] y;
        case (sel)
            5'd0:    y = a + 8'(cin);
            5'd1:    y = a + b + 8'(cin);
            5'd2:    y = a + ~b + 8'(cin);
            5'd3:    y = a - 8'd1 + 8'(cin);
            5'd4:    y = a & b;
            5'd5:    y = a | b;
            5'd6:    y = a ^ b;
            5'd7:    y = ~a;
            5'd8:    y = a << 1;
            5'd16:   y = a >> 1;
            5'd24:   y = b;
            default: y = a ^ b ^ 8'h5C;
        endcase
        return y;
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    assign alu_y = alu_model(alu_sel, alu_carry_in, alu_a, alu_b);

    alu_operand_sequencer #(.DATA_W(8), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_rd(instr_rd),
        .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
        .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
        .alu_sel(alu_sel), .alu_carry_in(alu_carry_in), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y),
        .result_valid(result_valid), .result_data(result_data), .result_rd(result_rd),
        .op_err(op_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        foreach (reg_m[i]) reg_m[i] = 8'h00;
        res_data_m = 8'h00;
        res_rd_m   = 2'd0;
    endtask

    task automatic waitReady();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_timeout", 32'(instr_ready), 32'd1);
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] waddr, input logic [7:0] wdata,
                                 input logic valid, input logic [5:0] op,
                                 input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd,
                                 input logic imm_en, input logic [7:0] imm);
        ext_we       = we;
        ext_waddr    = waddr;
        ext_wdata    = wdata;
        instr_valid  = valid;
        instr_op     = op;
        instr_ra     = ra;
        instr_rb     = rb;
        instr_rd     = rd;
        instr_imm_en = imm_en;
        instr_imm    = imm;
    endtask

    task automatic hostWrite(input logic [1:0] addr, input logic [7:0] data);
        waitReady();
        applyStimulus(1'b1, addr, data, 1'b0, 6'h00, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00);
        @(posedge clk); #1;
        ext_we = 1'b0;
        reg_m[addr] = data;
    endtask

    // One instruction through accept, ISSUE and WB, checked against the model at every step.
    task automatic runInstr(input logic we, input logic [1:0] waddr, input logic [7:0] wdata,
                            input logic [5:0] op, input logic [1:0] ra, input logic [1:0] rb,
                            input logic [1:0] rd, input logic imm_en, input logic [7:0] imm,
                            input logic hold_valid, input logic issue_we,
                            output logic [7:0] got_a, output logic [7:0] got_b,
                            output logic got_err, output logic [7:0] got_rdata,
                            output logic [1:0] got_rrd);
        logic [7:0] ea, eb, y;
        logic       legal;
        waitReady();
        applyStimulus(we, waddr, wdata, 1'b1, op, ra, rb, rd, imm_en, imm);
        ea = (we && waddr == ra) ? wdata : reg_m[ra];
        eb = imm_en ? imm : ((we && waddr == rb) ? wdata : reg_m[rb]);
        if (we) reg_m[waddr] = wdata;
        @(posedge clk); #1;
        if (!hold_valid) instr_valid = 1'b0;
        ext_we = 1'b0;
        checkOutput("issue_alu_a", 32'(alu_a), 32'(ea));
        checkOutput("issue_alu_b", 32'(alu_b), 32'(eb));
        checkOutput("issue_op", 32'({alu_sel, alu_carry_in}), 32'(op));
        checkOutput("issue_ready", 32'(instr_ready), 32'd0);
        checkOutput("issue_rvalid", 32'(result_valid), 32'd0);
        got_a = alu_a;
        got_b = alu_b;
        if (issue_we) begin
            ext_we    = 1'b1;
            ext_waddr = ra;
            ext_wdata = ~reg_m[ra];
        end
        y     = alu_model(op[5:1], op[0], ea, eb);
        legal = is_legal(op);
        if (legal) begin
            reg_m[rd]  = y;
            res_data_m = y;
            res_rd_m   = rd;
        end
        @(posedge clk); #1;
        ext_we = 1'b0;
        checkOutput("wb_rvalid", 32'(result_valid), 32'(legal));
        checkOutput("wb_op_err", 32'(op_err), 32'(!legal));
        checkOutput("wb_rdata", 32'(result_data), 32'(res_data_m));
        checkOutput("wb_rrd", 32'(result_rd), 32'(res_rd_m));
        checkOutput("wb_ready", 32'(instr_ready), 32'd0);
        checkOutput("wb_alu_hold", 32'(alu_a), 32'(ea));
        got_err   = op_err;
        got_rdata = result_data;
        got_rrd   = result_rd;
        @(posedge clk); #1;
        checkOutput("idle_ready", 32'(instr_ready), 32'd1);
        checkOutput("idle_rvalid", 32'(result_valid), 32'd0);
        checkOutput("idle_op_err", 32'(op_err), 32'd0);
    endtask

    initial begin
        logic [7:0] ga, gb, grd;
        logic       gerr;
        logic [1:0] grr;
        logic [5:0] rop;

        rst_n = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 6'h00, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00);
        model_reset();
        #1;
        checkOutput("rst_ready", 32'(instr_ready), 32'd1);
        checkOutput("rst_alu", 32'({alu_sel, alu_carry_in, alu_a, alu_b}), 32'd0);
        checkOutput("rst_result", 32'({result_valid, op_err, result_data, result_rd}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{1'b0, 2'd0, 8'h00, 6'b000010, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 8'h0F, 8'h01, 1'b0, 8'h10, 2'd2};
        vecs[1] = '{1'b0, 2'd0, 8'h00, 6'b000000, 2'd2, 2'd2, 2'd3, 1'b0, 8'h00, 8'h10, 8'h10, 1'b0, 8'h10, 2'd3};
        vecs[2] = '{1'b1, 2'd0, 8'hFF, 6'b000011, 2'd0, 2'd1, 2'd3, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'hFF, 2'd3};
        vecs[3] = '{1'b0, 2'd0, 8'h00, 6'b001001, 2'd3, 2'd2, 2'd0, 1'b0, 8'h00, 8'hFF, 8'h10, 1'b1, 8'hFF, 2'd3};
        vecs[4] = '{1'b0, 2'd0, 8'h00, 6'b000000, 2'd0, 2'd0, 2'd2, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 8'hFF, 2'd2};
        vecs[5] = '{1'b1, 2'd1, 8'hAA, 6'b001100, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 8'hAA, 8'hAA, 1'b0, 8'h00, 2'd1};
        vecs[6] = '{1'b0, 2'd0, 8'h00, 6'b000001, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 8'h01, 2'd0};

        hostWrite(2'd0, 8'h0F);
        hostWrite(2'd1, 8'h01);
        for (int i = 0; i < 7; i++) begin
            runInstr(vecs[i].ext_we, vecs[i].waddr, vecs[i].wdata, vecs[i].op, vecs[i].ra,
                     vecs[i].rb, vecs[i].rd, vecs[i].imm_en, vecs[i].imm, 1'b0, 1'b0,
                     ga, gb, gerr, grd, grr);
            checkOutput($sformatf("vec%0d_a", i), 32'(ga), 32'(vecs[i].exp_a));
            checkOutput($sformatf("vec%0d_b", i), 32'(gb), 32'(vecs[i].exp_b));
            checkOutput($sformatf("vec%0d_err", i), 32'(gerr), 32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_rdata", i), 32'(grd), 32'(vecs[i].exp_rdata));
            checkOutput($sformatf("vec%0d_rrd", i), 32'(grr), 32'(vecs[i].exp_rrd));
        end

        // Back-to-back: valid held high, second instruction taken three edges later,
        // and a host write attempted during ISSUE must be dropped.
        runInstr(1'b0, 2'd0, 8'h00, 6'b000010, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 1'b1, 1'b1,
                 ga, gb, gerr, grd, grr);
        runInstr(1'b0, 2'd0, 8'h00, 6'b000000, 2'd0, 2'd0, 2'd3, 1'b0, 8'h00, 1'b0, 1'b0,
                 ga, gb, gerr, grd, grr);

        // Reset asserted while an instruction sits in ISSUE.
        hostWrite(2'd2, 8'h55);
        waitReady();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 6'b000010, 2'd2, 2'd2, 2'd2, 1'b0, 8'h00);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checkOutput("midrst_pre_a", 32'(alu_a), 32'h55);
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput("midrst_alu", 32'({alu_sel, alu_carry_in, alu_a, alu_b}), 32'd0);
        checkOutput("midrst_result", 32'({result_valid, op_err, result_data, result_rd}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("postrst_rvalid", 32'(result_valid), 32'd0);
            checkOutput("postrst_ready", 32'(instr_ready), 32'd1);
        end
        runInstr(1'b0, 2'd0, 8'h00, 6'b000000, 2'd2, 2'd2, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0,
                 ga, gb, gerr, grd, grr);

        for (int i = 0; i < 40; i++) begin
            rop = ($urandom_range(0, 1) == 1) ? legal_ops[$urandom_range(0, 14)] : 6'($urandom);
            runInstr(($urandom_range(0, 2) == 0), 2'($urandom), 8'($urandom), rop,
                     2'($urandom), 2'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
                     8'($urandom), 1'b0, ($urandom_range(0, 4) == 0), ga, gb, gerr, grd, grr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
